// File: rtl/vga_pkg.sv
// Shared VGA-path definitions: default colour field widths, palette entry width,
// reset-table colour constants and cell codes.
package vga_pkg;

   localparam int DEF_RED_W = 3;
   localparam int DEF_GRN_W = 3;
   localparam int DEF_BLU_W = 2;
   localparam int COLOUR_W  = DEF_RED_W + DEF_GRN_W + DEF_BLU_W;
   localparam int ENTRY_W   = COLOUR_W + 1;  // blink bit on top

   localparam logic [COLOUR_W-1:0] BLACK       = 8'b000_000_00;
   localparam logic [COLOUR_W-1:0] RED         = 8'b111_000_00;
   localparam logic [COLOUR_W-1:0] PURPLE_BLUE = 8'b001_000_11;
   localparam logic [COLOUR_W-1:0] YELLOW      = 8'b111_111_00;
   localparam logic [COLOUR_W-1:0] GREEN       = 8'b000_111_00;

   localparam int EMPTY = 0;
   localparam int FOOD  = 1;
   localparam int WALL  = 2;
   localparam int HEAD  = 3;
   localparam int BODY  = 4;

endpackage

// File: rtl/palette_mapper_blink_timer.sv
// Blink phase generator: toggles phase every BLINK_FRAMES frame_tick pulses.
// Phase changes on the edge that takes the last tick of a half-period; never stalls.
module blink_timer #(
   parameter int BLINK_FRAMES = 30
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_tick,
   output logic phase
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (frame_tick) begin
         if (cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/palette_mapper.sv
// Cell code to RGB through a writable blinking palette; 2-clock fixed latency,
// no backpressure (writes and pixels are accepted every clock).
module palette_mapper
   import vga_pkg::*;
#(
   parameter int CODE_W       = 3,
   parameter int NUM_ENTRIES  = 8,
   parameter int RED_W        = DEF_RED_W,
   parameter int GRN_W        = DEF_GRN_W,
   parameter int BLU_W        = DEF_BLU_W,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             pix_valid,
   input  logic [CODE_W-1:0]                code,
   input  logic                             frame_tick,
   input  logic                             wr_en,
   input  logic [CODE_W-1:0]                wr_addr,
   input  logic [RED_W+GRN_W+BLU_W:0]       wr_data,
   output logic [RED_W-1:0]                 red,
   output logic [GRN_W-1:0]                 green,
   output logic [BLU_W-1:0]                 blue,
   output logic                             out_valid
);

   localparam int PAL_W = RED_W + GRN_W + BLU_W + 1;

   // Default colours are defined at 3/3/2; other widths keep the low bits of each field.
   function automatic logic [PAL_W-1:0] reset_entry(input int idx);
      logic [COLOUR_W-1:0] c;
      case (idx)
         EMPTY:   c = BLACK;
         FOOD:    c = RED;
         WALL:    c = PURPLE_BLUE;
         HEAD:    c = YELLOW;
         BODY:    c = GREEN;
         default: c = BLACK;
      endcase
      return {1'b0,
              RED_W'(c[COLOUR_W-1 -: DEF_RED_W]),
              GRN_W'(c[DEF_GRN_W+DEF_BLU_W-1 -: DEF_GRN_W]),
              BLU_W'(c[DEF_BLU_W-1:0])};
   endfunction

   logic [PAL_W-1:0]  pal [NUM_ENTRIES];
   logic [CODE_W-1:0] s1_code;
   logic              s1_vld;
   logic              phase;
   logic [PAL_W-1:0]  entry;
   logic              blank;

   blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .phase      (phase)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) pal[i] <= reset_entry(i);
      end else if (wr_en && (int'(wr_addr) < NUM_ENTRIES)) begin
         pal[wr_addr] <= wr_data;
      end
   end

   // Out-of-range codes read as an all-zero entry instead of indexing the table.
   always_comb begin
      entry = '0;
      if (int'(s1_code) < NUM_ENTRIES) entry = pal[s1_code];
      blank = !s1_vld || (entry[PAL_W-1] && phase);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_code   <= '0;
         s1_vld    <= 1'b0;
         red       <= '0;
         green     <= '0;
         blue      <= '0;
         out_valid <= 1'b0;
      end else begin
         s1_code   <= code;
         s1_vld    <= pix_valid;
         out_valid <= s1_vld;
         if (blank) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end else begin
            {red, green, blue} <= entry[PAL_W-2:0];
         end
      end
   end

endmodule

// File: doc/palette_mapper.md
Name: palette_mapper

Overview:
- Parametrised successor to the fixed cell-code-to-colour stage of the VGA path.
- Sits between the playfield/cell lookup (cell code per pixel) and the VGA output registers.
- Maps a CODE_W-bit cell code to 3/3/2 RGB through a run-time writable palette.
- Adds per-entry blink, active-video blanking and a matched-latency valid output.

Parameters:
- CODE_W, 3, width of cell code input.
- NUM_ENTRIES, 8, palette depth; legal range 1..2**CODE_W.
- RED_W, 3, red output width.
- GRN_W, 3, green output width.
- BLU_W, 2, blue output width.
- BLINK_FRAMES, 30, number of frame_tick pulses per blink half-period; must be >=1.

Ports:
- clk  in  1  pixel clock; all state is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  pixel is in the active video region.
- code  in  CODE_W  cell code for the current pixel.
- frame_tick  in  1  one-cycle pulse per frame, from VGA timing.
- wr_en  in  1  palette write strobe.
- wr_addr  in  CODE_W  palette entry to write.
- wr_data  in  RED_W+GRN_W+BLU_W+1  {blink, red, green, blue}, MSB is blink.
- red  out  RED_W  red output.
- green  out  GRN_W  green output.
- blue  out  BLU_W  blue output.
- out_valid  out  1  pix_valid delayed to align with RGB.

Behaviour:
- Reset is asynchronous on rst_n low: red/green/blue=0, out_valid=0, pipeline registers=0, blink counter=0, blink phase=0.
- Palette resets to:
  - entry 0 = black 000/000/00.
  - entry 1 = 111/000/00.
  - entry 2 = 001/000/11.
  - entry 3 = 111/111/00.
  - entry 4 = 000/111/00.
  - all remaining entries black.
  - all blink bits = 0.
- Reset mid-frame discards all in-flight pixels and any palette writes made since the last reset.
- Pipeline, fixed latency of 2 clocks from code/pix_valid to RGB/out_valid:
  - S1 registers code and pix_valid.
  - S2 performs the lookup and registers the RGB and out_valid.
- Blanking: if the S1 valid bit is 0, S2 outputs RGB=0. out_valid still tracks pix_valid with a 2-cycle delay.
- Out-of-range codes (code >= NUM_ENTRIES) output black. They never index beyond the table.
- Blink:
  - A counter increments on each frame_tick.
  - When it reaches BLINK_FRAMES-1 and a frame_tick arrives, it wraps to 0 and the blink phase toggles.
  - While phase=1, any entry with blink=1 outputs black. Entries with blink=0 are unaffected.
  - frame_tick held high counts once per clock; no edge detection is applied.
- Writes:
  - When wr_en=1, the entry at wr_addr is updated at that clock edge.
  - wr_addr >= NUM_ENTRIES is ignored, and the table is unchanged.
- Simultaneous read and write of the same entry on the same edge: S2 captures the old contents. The new value is visible to lookups from the following edge onward.
- Writes are accepted regardless of pix_valid. There is no backpressure; the block cannot stall.
- Output width rules:
  - RGB fields are taken directly from the palette entry.
  - There is no arithmetic on colour values.
  - Blink and blank force all bits to zero.

Decomposition:
- Shared package (vga_pkg) holds:
  - the default RED_W/GRN_W/BLU_W.
  - the palette entry width constant.
  - the named colour constants BLACK, RED, PURPLE_BLUE, YELLOW, GREEN used for the reset table.
  - the cell-code constants EMPTY=0, FOOD=1, WALL=2, HEAD=3, BODY=4.
- One natural sub-module, blink_timer:
  - inputs: clk, rst_n, frame_tick, parameter BLINK_FRAMES.
  - output: phase.
  - Keep the palette register file and the pipeline in the top level.

Test Plan:
- Reset then drive pix_valid=1 with codes 0..7, one per clock -> two cycles later RGB sequence is 000/000/00, 111/000/00, 001/000/11, 111/111/00, 000/111/00, then black for codes 5..7; out_valid rises exactly 2 clocks after pix_valid.
- pix_valid=0 with code=1 -> RGB=0 and out_valid=0 two cycles later. Toggling pix_valid every clock yields an alternating red/black output with matching out_valid.
- Write entry 4 = {1,000,000,11} with BLINK_FRAMES=2, then hold code=4 valid:
  - before any frame_tick, output is 000/000/11.
  - after 2 frame_tick pulses, output is black.
  - after 2 more pulses, output is 000/000/11 again.
- Write entry 1 = {0,010,101,01} on the same edge that code=1 sits in S1 -> that pixel outputs 111/000/00; the next code=1 pixel outputs 010/101/01.
- NUM_ENTRIES=5:
  - a write to wr_addr=6 is ignored; a lookup of code 6 outputs black.
  - entry 4 is unchanged.
- Assert rst_n low mid-stream, asynchronously between edges, after rewriting entry 2 -> outputs go 0 immediately without a clock edge; after release, code=2 outputs the default 001/000/11.
